vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster/timing generator; successor of the fixed 640x480@60 controller.
//  Generates hsync/vsync/de from generic porch/sync/active parameters with selectable sync polarity.
//  Runs on the system clock with a pixel clock-enable.
//  Issues a pixel request (req_x/req_y/req_de) PIPE pixel slots ahead of the outputs, so pixel sources
//  can have registered latency. Sits between the pixel source (logo/pattern) and the VGA pins.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch (pixels)
//  H_SYNC   96   hsync width (pixels)
//  H_BP     48   horizontal back porch (pixels)
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vsync width (lines)
//  V_BP     33   vertical back porch (lines)
//  H_POL    0    hsync active level (0 = active-low)
//  V_POL    0    vsync active level (0 = active-low)
//  CW       1    bits per colour channel
//  PIPE     1    pixel slots from request to output, legal range 1..4
//  XW       11   counter/coordinate width; 2**XW > H_TOTAL and 2**XW > V_TOTAL
// PORTS
//  clk        in   1      system clock, sole clock domain
//  clr        in   1      synchronous reset, active-low
//  pix_ce     in   1      pixel clock-enable; one pixel slot per clk edge with pix_ce=1
//  rgb_in     in   3*CW   {R,G,B} from pixel source, answers request issued PIPE slots earlier
//  req_x      out  XW     requested column (0..H_ACTIVE-1), 0 when req_de=0
//  req_y      out  XW     requested line (0..V_ACTIVE-1), 0 when req_de=0
//  req_de     out  1      request slot is in the active area
//  hsync      out  1      horizontal sync to monitor
//  vsync      out  1      vertical sync to monitor
//  de         out  1      output pixel is visible
//  rgb_out    out  3*CW   {R,G,B} to monitor, zero outside active area
//  line_start out  1      one-clk pulse: output slot hc=0 (every line, including blanking lines)
//  frame_start out 1      one-clk pulse: output slot (hc=0, vc=0)
// BEHAVIOUR
//  - Reset and clocking: clk is the only clock. clr is synchronous and active-low.
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - Line order: active [0,H_ACTIVE) -> FP -> SYNC -> BP. Frame order: the same, on vc.
//  - hsync_raw = H_POL when hc is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~H_POL.
//  - vsync_raw = V_POL when vc is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else ~V_POL.
//    vsync changes only at hc=0 slots.
//  - Reset (clr=0 at a clk edge): hc=vc=0 and delay line cleared.
//    Outputs: req_x=req_y=0, req_de=0, hsync=~H_POL, vsync=~V_POL, de=0, rgb_out=0, strobes=0.
//  - Mid-frame reset: aborts immediately, no completion of the line/frame.
//  - The first pix_ce after release issues slot (0,0).
//  - On each clk edge with pix_ce=1 (slot n):
//    * req_* registered from the current (hc,vc).
//    * hc <= hc+1. At hc=H_TOTAL-1: hc <= 0 and vc advances. At vc=V_TOTAL-1: vc <= 0.
//  - Delay line of PIPE stages, advancing only on pix_ce, carries {hsync_raw, vsync_raw, de_raw, hc==0, vc==0}.
//  - Output timing: at the pix_ce edge for slot n+PIPE, hsync/vsync/de show slot n.
//    rgb_out <= de_of_slot_n ? rgb_in : 0. rgb_in is sampled at that same edge.
//    The source therefore has PIPE-1 registered stages (PIPE=1: rgb_in combinational from req_*).
//  - pix_ce=0: counters, req_*, delay line, syncs, de and rgb_out all hold.
//  - Strobes: line_start/frame_start are high only in the clk cycle after the qualifying pix_ce edge.
//    They are never stretched by a low pix_ce.
//  - Start-up after reset: the first PIPE output slots carry reset-idle values (de=0, syncs inactive).
//  - Latency: request-to-output = PIPE pixel slots exactly, for any pix_ce pattern.
// TESTING
//  1. Defaults, pix_ce=1, clr=0 for 4 clk:
//     hsync low for 96 clk beginning at output slot hc=656; line_start period 800 clk.
//     vsync low on lines 490-491; frame_start period 420000 clk.
//  2. pix_ce toggling 1,0,1,0: all periods double (line 1600 clk).
//     line_start/frame_start stay exactly 1 clk wide; outputs hold on pix_ce=0.
//  3. PIPE=3, source model with 2 registered stages returning {R,G,B}=req_x[2:0]:
//     first de=1 exactly 3 slots after first req_de=1; rgb_out[2:0]==column index throughout.
//  4. H_ACTIVE=8,H_FP=1,H_SYNC=2,H_BP=1, V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1, H_POL=V_POL=1:
//     line 12 slots, frame 7 lines; hsync=1 at output slots 9-10; vsync=1 on line 5 only.
//  5. clr=0 at hc=300,vc=200 for 1 clk: the next cycle shows idle values.
//     The first pix_ce after release requests (0,0), and frame_start fires PIPE slots later.
//  6. rgb_in held all-ones: rgb_out=0 in every slot with de=0, all-ones in every slot with de=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator with a look-ahead pixel request port.
// Pixel slots are marked by pix_ce on clk; monitor outputs trail requests by PIPE slots.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 1,
    parameter int PIPE     = 1,
    parameter int XW       = 11
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            pix_ce,
    input  logic [3*CW-1:0] rgb_in,
    output logic [XW-1:0]   req_x,
    output logic [XW-1:0]   req_y,
    output logic            req_de,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic [3*CW-1:0] rgb_out,
    output logic            line_start,
    output logic            frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] V_LAST = XW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] V_ACT  = XW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] VS_BEG = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0] VS_END = XW'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line tag per slot: {hsync, vsync, de, first column, first line}
    localparam int TAG_W = 5;
    localparam int DLY_W = PIPE * TAG_W;
    localparam logic [TAG_W-1:0] IDLE_TAG = {~H_POL, ~V_POL, 3'b000};

    logic [XW-1:0]    hc;
    logic [XW-1:0]    vc;
    logic             hs_raw;
    logic             vs_raw;
    logic             de_raw;
    logic [TAG_W-1:0] cur_tag;
    logic [TAG_W-1:0] out_tag;
    logic [DLY_W-1:0] dly_q;

    always_comb begin
        hs_raw  = (hc >= HS_BEG && hc < HS_END) ? H_POL : ~H_POL;
        vs_raw  = (vc >= VS_BEG && vc < VS_END) ? V_POL : ~V_POL;
        de_raw  = (hc < H_ACT) && (vc < V_ACT);
        cur_tag = {hs_raw, vs_raw, de_raw, hc == '0, vc == '0};
        out_tag = dly_q[DLY_W-1 -: TAG_W];
    end

    // Request/response contract: the request for slot n is registered at slot n's
    // pix_ce edge; rgb_in must carry that slot's colour at the pix_ce edge of slot
    // n+PIPE, i.e. the source has PIPE-1 registers advancing on pix_ce.
    always_ff @(posedge clk) begin
        if (!clr) begin
            hc          <= '0;
            vc          <= '0;
            req_x       <= '0;
            req_y       <= '0;
            req_de      <= 1'b0;
            dly_q       <= {PIPE{IDLE_TAG}};
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            rgb_out     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_ce) begin
                req_de <= de_raw;
                req_x  <= de_raw ? hc : '0;
                req_y  <= de_raw ? vc : '0;

                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end

                dly_q <= (dly_q << TAG_W) | DLY_W'(cur_tag);

                hsync       <= out_tag[4];
                vsync       <= out_tag[3];
                de          <= out_tag[2];
                rgb_out     <= out_tag[2] ? rgb_in : '0;
                line_start  <= out_tag[1];
                frame_start <= out_tag[1] & out_tag[0];
            end
        end
    end
endmodule
